wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_hold_slot.sv | 48 ++++
 rtl/wb_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and types for the write-back arbiter and its holding slots.
package wb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int REG_WID     = 5;
    localparam int SB_SIZE_WID = 4;

    // Scoreboard position used when no entry has been written back yet.
    localparam logic [SB_SIZE_WID-1:0] INVALID_POS = '1;

    // Which requester received the most recent grant (round-robin memory).
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LS  = 1'b1
    } grant_e;

    // One pending write-back: scoreboard entry, destination register, result.
    typedef struct packed {
        logic [SB_SIZE_WID-1:0] pos;
        logic [REG_WID-1:0]     rd;
        logic [XLEN-1:0]        data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hold_slot.sv
// Single-entry holding slot in front of the write-back arbiter. The slot
// accepts a new result whenever it is empty or is being drained this cycle,
// so a requester that wins every arbitration can stream one result per cycle.
module wb_hold_slot
    import wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    input  wb_entry_t in_entry,
    input  logic      grant,
    output logic      ready,
    output logic      slot_valid,
    output wb_entry_t slot_entry
);

    logic      valid_q, valid_d;
    wb_entry_t entry_q, entry_d;

    // Ready depends only on slot state and the grant, never on in_valid.
    assign ready      = !valid_q || grant;
    assign slot_valid = valid_q;
    assign slot_entry = entry_q;

    // Next state: a reload during a grant keeps the slot full with new data.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (in_valid && ready) begin
            valid_d = 1'b1;
            entry_d = in_entry;
        end else if (grant) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register; reset drops any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load/store results into a single
// registered write-back port (scoreboard release + register-file write).
// Ties are broken round-robin so neither requester waits more than one cycle.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [SB_SIZE_WID-1:0] alu_pos,
    input  logic [REG_WID-1:0]     alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ls_valid,
    output logic                   ls_ready,
    input  logic [SB_SIZE_WID-1:0] ls_pos,
    input  logic [REG_WID-1:0]     ls_rd,
    input  logic [XLEN-1:0]        ls_data,
    output logic                   wb_valid,
    output logic [SB_SIZE_WID-1:0] wb_pos,
    output logic [REG_WID-1:0]     wb_rd,
    output logic                   reg_we,
    output logic [REG_WID-1:0]     reg_waddr,
    output logic [XLEN-1:0]        reg_wdata
);

    // Index 0 is the ALU, index 1 the load/store unit (matches grant_e).
    logic [1:0] in_valid;
    logic [1:0] slot_ready;
    logic [1:0] slot_valid;
    logic [1:0] grant;
    wb_entry_t  in_entry   [2];
    wb_entry_t  slot_entry [2];
    wb_entry_t  winner;

    grant_e                 last_grant_q, last_grant_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [SB_SIZE_WID-1:0] wb_pos_q, wb_pos_d;
    logic [REG_WID-1:0]     wb_rd_q, wb_rd_d;
    logic                   reg_we_q, reg_we_d;
    logic [XLEN-1:0]        reg_wdata_q, reg_wdata_d;

    assign in_valid    = {ls_valid, alu_valid};
    assign in_entry[0] = '{pos: alu_pos, rd: alu_rd, data: alu_data};
    assign in_entry[1] = '{pos: ls_pos,  rd: ls_rd,  data: ls_data};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            wb_hold_slot u_slot (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[gi]),
                .in_entry   (in_entry[gi]),
                .grant      (grant[gi]),
                .ready      (slot_ready[gi]),
                .slot_valid (slot_valid[gi]),
                .slot_entry (slot_entry[gi])
            );
        end
    endgenerate

    assign alu_ready = slot_ready[0];
    assign ls_ready  = slot_ready[1];

    // Grant selection: lone valid slot wins, ties go to the slot not granted last.
    always_comb begin
        grant = 2'b00;
        case (slot_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == GRANT_LS) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Next-state for round-robin memory and the registered write-back port.
    always_comb begin
        last_grant_d = last_grant_q;
        wb_valid_d   = 1'b0;
        reg_we_d     = 1'b0;
        wb_pos_d     = wb_pos_q;
        wb_rd_d      = wb_rd_q;
        reg_wdata_d  = reg_wdata_q;
        winner       = grant[1] ? slot_entry[1] : slot_entry[0];
        if (grant != 2'b00) begin
            last_grant_d = grant[1] ? GRANT_LS : GRANT_ALU;
            wb_valid_d   = 1'b1;
            wb_pos_d     = winner.pos;
            wb_rd_d      = winner.rd;
            reg_wdata_d  = winner.data;
            // x0 is never written, but the scoreboard entry is still freed.
            reg_we_d     = (winner.rd != '0);
        end
    end

    // State register; ALU wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_LS;
            wb_valid_q   <= 1'b0;
            wb_pos_q     <= INVALID_POS;
            wb_rd_q      <= '0;
            reg_we_q     <= 1'b0;
            reg_wdata_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_valid_q   <= wb_valid_d;
            wb_pos_q     <= wb_pos_d;
            wb_rd_q      <= wb_rd_d;
            reg_we_q     <= reg_we_d;
            reg_wdata_q  <= reg_wdata_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_pos    = wb_pos_q;
    assign wb_rd     = wb_rd_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = wb_rd_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for contention and streaming.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alu_valid, alu_ready;
    logic [SB_SIZE_WID-1:0] alu_pos;
    logic [REG_WID-1:0]     alu_rd;
    logic [XLEN-1:0]        alu_data;
    logic                   ls_valid, ls_ready;
    logic [SB_SIZE_WID-1:0] ls_pos;
    logic [REG_WID-1:0]     ls_rd;
    logic [XLEN-1:0]        ls_data;
    logic                   wb_valid;
    logic [SB_SIZE_WID-1:0] wb_pos;
    logic [REG_WID-1:0]     wb_rd;
    logic                   reg_we;
    logic [REG_WID-1:0]     reg_waddr;
    logic [XLEN-1:0]        reg_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_pos   (alu_pos),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ls_valid  (ls_valid),
        .ls_ready  (ls_ready),
        .ls_pos    (ls_pos),
        .ls_rd     (ls_rd),
        .ls_data   (ls_data),
        .wb_valid  (wb_valid),
        .wb_pos    (wb_pos),
        .wb_rd     (wb_rd),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    // Inputs driven before an edge; ready expected before it, outputs after it.
    typedef struct {
        int rst;
        int av; int apos; int ard; int adata;
        int lv; int lpos; int lrd; int ldata;
        int chk_rdy; int e_ar; int e_lr;
        int e_wv; int e_pos; int e_rd; int e_we; int e_wdata;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_pos = '0; alu_rd = '0; alu_data = '0;
        ls_valid  = 1'b0; ls_pos  = '0; ls_rd  = '0; ls_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ai, li, pulses;
        bit started, a_acc, l_acc;

        //        rst av apos ard adata    lv lpos lrd ldata   chk ar lr  wv pos rd we wdata
        vec[0]  = '{0, 1, 3, 5, 'hDEAD,   0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};
        vec[1]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   1, 3,  5, 1, 'hDEAD};
        vec[2]  = '{1, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};
        vec[3]  = '{0, 1, 1, 2, 'h111,    1, 9, 7, 'h999,   1, 1, 1,   0, 15, 0, 0, 0};
        vec[4]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 0,   1, 1,  2, 1, 'h111};
        vec[5]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   1, 9,  7, 1, 'h999};
        vec[6]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 9,  7, 0, 'h999};
        vec[7]  = '{0, 0, 0, 0, 0,        1, 8, 0, 'h888,   1, 1, 1,   0, 9,  7, 0, 'h999};
        vec[8]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   1, 8,  0, 0, 'h888};
        vec[9]  = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 8,  0, 0, 'h888};
        vec[10] = '{0, 1, 4, 3, 'h444,    1, 5, 4, 'h555,   1, 1, 1,   0, 8,  0, 0, 'h888};
        vec[11] = '{1, 0, 0, 0, 0,        0, 0, 0, 0,       0, 0, 0,   0, 15, 0, 0, 0};
        vec[12] = '{1, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};
        vec[13] = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};
        vec[14] = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};
        vec[15] = '{0, 0, 0, 0, 0,        0, 0, 0, 0,       1, 1, 1,   0, 15, 0, 0, 0};

        // Initial reset: two edges, then check the reset state.
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check("reset_alu_ready", 32'(alu_ready), 1);
        check("reset_ls_ready",  32'(ls_ready),  1);
        check("reset_wb_valid",  32'(wb_valid),  0);
        check("reset_reg_we",    32'(reg_we),    0);
        check("reset_wb_pos",    32'(wb_pos),    32'(INVALID_POS));
        check("reset_wb_rd",     32'(wb_rd),     0);
        check("reset_reg_waddr", 32'(reg_waddr), 0);
        check("reset_reg_wdata", reg_wdata,      0);
        $display("reset: wb_pos=0x%0h ready=%0b/%0b", wb_pos, alu_ready, ls_ready);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            rst       = (vec[i].rst != 0);
            alu_valid = (vec[i].av != 0);
            alu_pos   = SB_SIZE_WID'(vec[i].apos);
            alu_rd    = REG_WID'(vec[i].ard);
            alu_data  = XLEN'(vec[i].adata);
            ls_valid  = (vec[i].lv != 0);
            ls_pos    = SB_SIZE_WID'(vec[i].lpos);
            ls_rd     = REG_WID'(vec[i].lrd);
            ls_data   = XLEN'(vec[i].ldata);
            #1;
            if (vec[i].chk_rdy != 0) begin
                check($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vec[i].e_ar));
                check($sformatf("vec%0d_ls_ready", i),  32'(ls_ready),  32'(vec[i].e_lr));
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_wb_valid", i),  32'(wb_valid),  32'(vec[i].e_wv));
            check($sformatf("vec%0d_wb_pos", i),    32'(wb_pos),    32'(vec[i].e_pos));
            check($sformatf("vec%0d_wb_rd", i),     32'(wb_rd),     32'(vec[i].e_rd));
            check($sformatf("vec%0d_reg_waddr", i), 32'(reg_waddr), 32'(vec[i].e_rd));
            check($sformatf("vec%0d_reg_we", i),    32'(reg_we),    32'(vec[i].e_we));
            check($sformatf("vec%0d_reg_wdata", i), reg_wdata,      32'(vec[i].e_wdata));
            $display("vec%0d: rst=%0b alu_v=%0b ls_v=%0b -> wb_valid=%0b wb_pos=%0d wb_rd=%0d reg_we=%0b wdata=0x%0h",
                     i, rst, alu_valid, ls_valid, wb_valid, wb_pos, wb_rd, reg_we, reg_wdata);
        end

        // Sustained contention: ALU offers even positions, LS odd ones; the
        // round-robin must write back positions 0..9 in order with no gaps.
        ai = 0; li = 0; pulses = 0; started = 0;
        for (int cyc = 0; cyc < 40 && pulses < 10; cyc++) begin
            @(negedge clk);
            rst       = 1'b0;
            alu_valid = (ai < 5);
            alu_pos   = SB_SIZE_WID'(2 * ai);
            alu_rd    = REG_WID'(2 * ai + 1);
            alu_data  = XLEN'(32'h1000 + 2 * ai);
            ls_valid  = (li < 5);
            ls_pos    = SB_SIZE_WID'(2 * li + 1);
            ls_rd     = REG_WID'(2 * li + 2);
            ls_data   = XLEN'(32'h1000 + 2 * li + 1);
            #1;
            a_acc = alu_valid && alu_ready;
            l_acc = ls_valid && ls_ready;
            @(posedge clk);
            if (a_acc) ai++;
            if (l_acc) li++;
            #1;
            if (wb_valid) begin
                check($sformatf("cont%0d_wb_pos", pulses),    32'(wb_pos),    32'(pulses));
                check($sformatf("cont%0d_wb_rd", pulses),     32'(wb_rd),     32'(pulses + 1));
                check($sformatf("cont%0d_reg_wdata", pulses), reg_wdata,      32'h1000 + 32'(pulses));
                check($sformatf("cont%0d_reg_we", pulses),    32'(reg_we),    1);
                $display("contention pulse %0d: wb_pos=%0d wb_rd=%0d wdata=0x%0h", pulses, wb_pos, wb_rd, reg_wdata);
                pulses++;
                started = 1;
            end else if (started) begin
                check($sformatf("cont_gap_cyc%0d", cyc), 32'(wb_valid), 1);
            end
        end
        check("cont_pulse_count", 32'(pulses), 10);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("cont_drained", 32'(wb_valid), 0);

        // Back-to-back ALU stream with LS idle: ready stays high, one
        // write-back per cycle, order preserved.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            alu_valid = (c < 6);
            alu_pos   = SB_SIZE_WID'(10 + c);
            alu_rd    = REG_WID'(c + 1);
            alu_data  = XLEN'(32'hA000 + c);
            #1;
            if (c < 6) check($sformatf("stream%0d_alu_ready", c), 32'(alu_ready), 1);
            @(posedge clk);
            #1;
            if (c >= 1 && c <= 6) begin
                check($sformatf("stream%0d_wb_valid", c),  32'(wb_valid),  1);
                check($sformatf("stream%0d_wb_pos", c),    32'(wb_pos),    32'(10 + c - 1));
                check($sformatf("stream%0d_reg_waddr", c), 32'(reg_waddr), 32'(c));
                check($sformatf("stream%0d_reg_wdata", c), reg_wdata,      32'hA000 + 32'(c - 1));
            end else begin
                check($sformatf("stream%0d_wb_valid", c),  32'(wb_valid),  0);
            end
            $display("stream cycle %0d: alu_v=%0b ready=%0b -> wb_valid=%0b wb_pos=%0d", c, alu_valid, alu_ready, wb_valid, wb_pos);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
